fir_filter_pipe: RTL and testbench

Parametrised, fully pipelined, streaming FIR filter. It is the successor to the team's fixed 3-tap filter and has four new capabilities: configurable tap count and widths, runtime-loadable coefficients, round-half-up with saturation, and a valid/ready handshake with backpressure. It sits between the sample source (ADC front end or test pattern generator) and downstream DSP or the DAC path.

---
 rtl/fir_filter_pipe_pkg.sv | 40 ++++
 rtl/fir_round_sat.sv | 52 +++++
 rtl/fir_filter_pipe.sv | 141 ++++++++++++++
 tb/tb_fir_filter_pipe.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_filter_pipe_pkg.sv
// Shared FIR/DSP definitions: accumulator width derivation, ceil-log2 and
// saturation limits for a signed DATA_W-bit output.
//
// Contents:
//   COEF_ADDR_W - width of the coefficient address bus
//   clog2_f     - ceil(log2(n)) for n >= 1
//   acc_width   - accumulator width that cannot overflow over all taps
//   sat_hi      - largest signed value representable in dw bits
//   sat_lo      - smallest signed value representable in dw bits
package fir_filter_pipe_pkg;

    localparam int unsigned COEF_ADDR_W = 5;

    function automatic int unsigned clog2_f(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Each product is dw+cw bits; summing taps products needs clog2(taps) growth bits.
    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned cw,
                                              input int unsigned taps);
        return dw + cw + clog2_f(taps);
    endfunction

    function automatic longint sat_hi(input int unsigned dw);
        return (longint'(1) << (dw - 1)) - longint'(1);
    endfunction

    function automatic longint sat_lo(input int unsigned dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic right shift and saturation of the
// FIR accumulator into a DATA_W-bit signed sample.
//
// Ports:
//   acc     in   ACC_W   signed accumulator value
//   result  out  DATA_W  rounded, shifted and clamped sample
//   sat     out  1       result was clamped to the DATA_W range
module fir_round_sat
    import fir_filter_pipe_pkg::*;
#(
    parameter int unsigned ACC_W  = 35,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned SHIFT  = 14
) (
    input  logic signed [ACC_W-1:0]  acc,
    output logic signed [DATA_W-1:0] result,
    output logic                     sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int unsigned RW = ACC_W + 1;

    localparam logic signed [RW-1:0] SAT_HI = RW'(sat_hi(DATA_W));
    localparam logic signed [RW-1:0] SAT_LO = RW'(sat_lo(DATA_W));

    logic signed [RW-1:0] ext;
    logic signed [RW-1:0] rounded;

    assign ext = RW'(acc);

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RW-1:0] HALF = RW'(64'd1 << (SHIFT - 1));
            assign rounded = (ext + HALF) >>> SHIFT;
        end else begin : g_no_round
            assign rounded = ext;
        end
    endgenerate

    always_comb begin
        sat    = 1'b0;
        result = rounded[DATA_W-1:0];
        if (rounded > SAT_HI) begin
            sat    = 1'b1;
            result = SAT_HI[DATA_W-1:0];
        end else if (rounded < SAT_LO) begin
            sat    = 1'b1;
            result = SAT_LO[DATA_W-1:0];
        end
    end

endmodule

// File: rtl/fir_filter_pipe.sv
// Streaming, fully pipelined FIR filter with runtime-loadable coefficients,
// round-half-up/saturating output and a valid/ready handshake.
// Pipeline: S0 delay line, S1 products, S2 adder tree, S3 round/saturate.
//
// Ports:
//   clk         in   1       clock
//   reset       in   1       asynchronous active-high reset
//   clear       in   1       synchronous flush of delay line and valids
//   in_valid    in   1       sample_in valid
//   in_ready    out  1       sample accepted this cycle if in_valid
//   sample_in   in   DATA_W  input sample, signed
//   out_valid   out  1       sample_out valid
//   out_ready   in   1       downstream accepts sample_out
//   sample_out  out  DATA_W  filtered sample, signed
//   sat_flag    out  1       sample_out was clipped
//   coef_we     in   1       coefficient write strobe
//   coef_addr   in   5       tap index; indices >= TAPS are ignored
//   coef_data   in   COEF_W  coefficient value, signed
module fir_filter_pipe
    import fir_filter_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned TAPS   = 8,
    parameter int unsigned SHIFT  = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] sample_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sat_flag,
    input  logic                     coef_we,
    input  logic [COEF_ADDR_W-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0] coef_data
);

    localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int unsigned PROD_W = DATA_W + COEF_W;

    // Unity gain in the coefficient Q-format, so reset state is pass-through.
    localparam logic signed [COEF_W-1:0] C_UNITY = COEF_W'(64'd1 << SHIFT);

    logic en;
    logic accept;

    logic signed [DATA_W-1:0] x_q    [TAPS];
    logic signed [COEF_W-1:0] c_q    [TAPS];
    logic signed [PROD_W-1:0] prod_q [TAPS];
    logic signed [ACC_W-1:0]  sum_d;
    logic signed [ACC_W-1:0]  sum_q;
    logic                     v0_q;
    logic                     v1_q;
    logic                     v2_q;

    logic signed [DATA_W-1:0] rs_out;
    logic                     rs_sat;

    // The whole pipeline advances together; it only stalls when the output
    // register holds a sample that downstream has not taken.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && !clear;
    assign accept   = in_valid && in_ready;

    // S0: delay line, shifts only on accepted samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (clear) begin
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
        end else if (accept) begin
            x_q[0] <= sample_in;
            for (int k = 1; k < TAPS; k++) x_q[k] <= x_q[k-1];
        end
    end

    // Coefficient file: writable at any time, independent of stall and clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_q[0] <= C_UNITY;
            for (int k = 1; k < TAPS; k++) c_q[k] <= '0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == COEF_ADDR_W'(k)) c_q[k] <= coef_data;
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < TAPS; k++) sum_d = sum_d + ACC_W'(prod_q[k]);
    end

    fir_round_sat #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .SHIFT  (SHIFT)
    ) u_round_sat (
        .acc    (sum_q),
        .result (rs_out),
        .sat    (rs_sat)
    );

    // S1..S3 datapath and valid chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_q       <= 1'b0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            out_valid  <= 1'b0;
            for (int k = 0; k < TAPS; k++) prod_q[k] <= '0;
            sum_q      <= '0;
            sample_out <= '0;
            sat_flag   <= 1'b0;
        end else if (clear) begin
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            out_valid <= 1'b0;
        end else if (en) begin
            v0_q      <= accept;
            v1_q      <= v0_q;
            v2_q      <= v1_q;
            out_valid <= v2_q;
            for (int k = 0; k < TAPS; k++) begin
                prod_q[k] <= PROD_W'(x_q[k]) * PROD_W'(c_q[k]);
            end
            sum_q <= sum_d;
            // Hold the last result across bubbles so the output only moves on data.
            if (v2_q) begin
                sample_out <= rs_out;
                sat_flag   <= rs_sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter_pipe.sv
// Directed self-checking bench for fir_filter_pipe with default parameters.
module tb_fir_filter_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               clear;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] sample_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] sample_out;
    logic               sat_flag;
    logic               coef_we;
    logic [4:0]         coef_addr;
    logic signed [15:0] coef_data;

    int checks = 0;
    int errors = 0;

    logic signed [15:0] q_data[$];
    logic               q_sat[$];

    fir_filter_pipe #(
        .DATA_W (16),
        .COEF_W (16),
        .TAPS   (8),
        .SHIFT  (14)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .sample_in  (sample_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sample_out (sample_out),
        .sat_flag   (sat_flag),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data)
    );

    always #5 clk = ~clk;

    // Inputs only change at posedge+1, so the negedge sees the values the
    // next posedge will act on.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            q_data.push_back(sample_out);
            q_sat.push_back(sat_flag);
        end
    end

    task automatic check(input string tag, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [15:0] v);
        int n;
        n = 0;
        sample_in = v;
        in_valid  = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                check("send_timeout", in_ready, 1);
                break;
            end
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = 5'(addr);
        coef_data = 16'(data);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic drain(input int n);
        int t;
        t = 0;
        while (q_data.size() < n && t < 300) begin
            tick();
            t++;
        end
        if (q_data.size() < n) check("drain_timeout", q_data.size(), n);
    endtask

    task automatic expect_out(input string tag, input int exp, input logic exp_sat);
        if (q_data.size() == 0) begin
            check({tag, "_missing"}, q_data.size(), 1);
        end else begin
            check(tag, q_data.pop_front(), exp);
            check({tag, "_sat"}, q_sat.pop_front(), exp_sat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [15:0] held;

        reset     = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        sample_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_sample_out", sample_out, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);
        tick();

        // Pass-through with latency: valid after the third edge following acceptance.
        send(16'sd100);
        check("lat_e0", out_valid, 0);
        tick();
        check("lat_e1", out_valid, 0);
        tick();
        check("lat_e2", out_valid, 0);
        tick();
        check("lat_e3", out_valid, 1);
        check("lat_e3_data", sample_out, 100);
        send(16'sd200);
        send(-16'sd300);
        drain(3);
        expect_out("pass0", 100, 1'b0);
        expect_out("pass1", 200, 1'b0);
        expect_out("pass2", -300, 1'b0);

        // Impulse response with c[k] = 1024*k.
        do_clear();
        for (int k = 0; k < 8; k++) wcoef(k, 1024 * k);
        send(16'sd16384);
        repeat (8) send(16'sd0);
        drain(9);
        for (int k = 0; k < 8; k++) expect_out($sformatf("imp%0d", k), 1024 * k, 1'b0);
        expect_out("imp8", 0, 1'b0);

        // Rounding with c[0] = 1; out-of-range writes must not land anywhere.
        do_clear();
        wcoef(0, 1);
        for (int k = 1; k < 8; k++) wcoef(k, 0);
        wcoef(8, 5000);
        wcoef(31, 7000);
        send(16'sd8192);
        send(16'sd8191);
        send(-16'sd8192);
        send(-16'sd8193);
        drain(4);
        expect_out("rnd0", 1, 1'b0);
        expect_out("rnd1", 0, 1'b0);
        expect_out("rnd2", 0, 1'b0);
        expect_out("rnd3", -1, 1'b0);

        // Saturation: unity gain on every tap.
        do_clear();
        for (int k = 0; k < 8; k++) wcoef(k, 16384);
        repeat (8) send(16'sd30000);
        repeat (8) send(-16'sd30000);
        drain(16);
        for (int i = 0; i < 16; i++) begin
            if (i == 0)       expect_out($sformatf("sat%0d", i), 30000, 1'b0);
            else if (i < 11)  expect_out($sformatf("sat%0d", i), 32767, 1'b1);
            else if (i == 11) expect_out($sformatf("sat%0d", i), 0, 1'b0);
            else              expect_out($sformatf("sat%0d", i), -32768, 1'b1);
        end

        // Backpressure: y = x[n] + x[n-1]/2, five stalled cycles mid-stream.
        do_clear();
        wcoef(0, 16384);
        wcoef(1, 8192);
        for (int k = 2; k < 8; k++) wcoef(k, 0);
        fork
            begin
                for (int i = 1; i <= 12; i++) send(16'(100 * i));
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = sample_out;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    check($sformatf("bp_in_ready%0d", c), in_ready, 0);
                    check($sformatf("bp_valid%0d", c), out_valid, 1);
                    check($sformatf("bp_hold%0d", c), sample_out, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain(12);
        for (int i = 1; i <= 12; i++) expect_out($sformatf("bp%0d", i), 150 * i - 50, 1'b0);

        // Clear mid-stream: flushes history and in-flight data, keeps coefficients.
        send(16'sd1000);
        send(16'sd1000);
        send(16'sd1000);
        clear     = 1'b1;
        in_valid  = 1'b1;
        sample_in = 16'sd5000;
        @(negedge clk);
        check("clr_in_ready", in_ready, 0);
        tick();
        check("clr_out_valid", out_valid, 0);
        clear    = 1'b0;
        in_valid = 1'b0;
        q_data.delete();
        q_sat.delete();
        send(16'sd16384);
        send(16'sd0);
        send(16'sd0);
        drain(3);
        expect_out("clr0", 16384, 1'b0);
        expect_out("clr1", 8192, 1'b0);
        expect_out("clr2", 0, 1'b0);

        // Reset mid-stream: back to pass-through, outputs zeroed.
        wcoef(3, 777);
        send(16'sd500);
        send(16'sd600);
        #3;
        reset = 1'b1;
        #1;
        check("mrst_out_valid", out_valid, 0);
        check("mrst_sample_out", sample_out, 0);
        check("mrst_sat_flag", sat_flag, 0);
        check("mrst_in_ready", in_ready, 1);
        tick();
        reset = 1'b0;
        q_data.delete();
        q_sat.delete();
        send(16'sd100);
        send(-16'sd7);
        drain(2);
        expect_out("mrst0", 100, 1'b0);
        expect_out("mrst1", -7, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
